// File: rtl/instruction_fetch_pkg.sv
// -----------------------------------------------------------------------------
// instruction_fetch_pkg
// Shared definitions for the instruction fetch stage:
//   XLEN        - datapath / address width
//   PC_STEP     - byte increment between sequential instructions
//   NOP         - value the IF/ID instruction register holds after reset
//   fetch_state_e - fetch FSM state encoding
// -----------------------------------------------------------------------------
package instruction_fetch_pkg;

  localparam int unsigned XLEN = 32;

  localparam logic [XLEN-1:0] PC_STEP = 32'd4;
  localparam logic [XLEN-1:0] NOP     = 32'h0000_0000;

  // Word-aligned address: byte-offset bits are forced to zero.
  localparam logic [XLEN-1:0] ALIGN_MASK = 32'hFFFF_FFFC;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,  // one settle cycle after reset release
    S_RUN  = 2'd1,  // fetching, one instruction per cycle when the slot frees
    S_HALT = 2'd2   // frozen until a redirect or reset
  } fetch_state_e;

endpackage : instruction_fetch_pkg

// File: rtl/instruction_fetch_pc_register.sv
// -----------------------------------------------------------------------------
// instruction_fetch_pc_register
// Program counter with its next-pc mux. Priority: redirect, then sequential
// advance, otherwise hold.
// Ports:
//   clk            - clock, rising edge
//   rst_n          - asynchronous active-low reset, loads RESET_PC
//   redirect_valid - load the aligned redirect target this edge
//   redirect_pc    - redirect target; bits [1:0] are dropped
//   advance        - step pc by PC_STEP this edge (ignored during redirect)
//   pc             - current program counter
// -----------------------------------------------------------------------------
module instruction_fetch_pc_register
  import instruction_fetch_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  input  logic            advance,
  output logic [XLEN-1:0] pc
);

  logic [XLEN-1:0] pc_q;
  logic [XLEN-1:0] pc_d;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves
    // it unassigned; that is what keeps a latch from being inferred.
    pc_d = pc_q;
    if (redirect_valid) begin
      pc_d = redirect_pc & ALIGN_MASK;
    end else if (advance) begin
      // Unsigned 32-bit add; 32'hFFFF_FFFC wraps to 0 naturally.
      pc_d = pc_q + PC_STEP;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q <= RESET_PC & ALIGN_MASK;
    end else begin
      pc_q <= pc_d;
    end
  end

  assign pc = pc_q;

endmodule : instruction_fetch_pc_register

// File: rtl/instruction_fetch.sv
// -----------------------------------------------------------------------------
// instruction_fetch
// Fetch stage: owns the pc, drives a combinational instruction memory and
// captures each returned instruction with its pc into a registered IF/ID
// output under a valid/ready handshake. Redirects flush and restart fetch;
// halt freezes fetch until the next redirect or reset.
// Ports:
//   clk, rst_n      - clock (rising edge) and async active-low reset
//   imem_addr       - byte address to instruction memory (= pc)
//   imem_instr      - instruction returned combinationally for imem_addr
//   redirect_valid  - one-cycle redirect request (taken branch / jump)
//   redirect_pc     - redirect target, low two bits ignored
//   halt            - level request to stop fetching
//   out_valid       - out_instr / out_pc hold a fetched instruction
//   out_ready       - decode accepts the output this cycle
//   out_instr       - fetched instruction
//   out_pc          - address out_instr was fetched from
//   halted          - high while the FSM sits in S_HALT
//   fetch_count     - number of accepted handshakes, wrapping
// -----------------------------------------------------------------------------
module instruction_fetch
  import instruction_fetch_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC    = 32'h0000_0000,
  parameter int unsigned     COUNT_WIDTH = 32
) (
  input  logic                   clk,
  input  logic                   rst_n,
  output logic [XLEN-1:0]        imem_addr,
  input  logic [XLEN-1:0]        imem_instr,
  input  logic                   redirect_valid,
  input  logic [XLEN-1:0]        redirect_pc,
  input  logic                   halt,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [XLEN-1:0]        out_instr,
  output logic [XLEN-1:0]        out_pc,
  output logic                   halted,
  output logic [COUNT_WIDTH-1:0] fetch_count
);

  fetch_state_e state_q, state_d;

  logic [XLEN-1:0]        pc;
  logic                   out_valid_q, out_valid_d;
  logic [XLEN-1:0]        out_instr_q;
  logic [XLEN-1:0]        out_pc_q;
  logic [COUNT_WIDTH-1:0] fetch_count_q;

  logic accept;
  logic slot_free;
  logic capture;

  assign accept    = out_valid_q && out_ready;
  assign slot_free = !out_valid_q || out_ready;

  // ---------------------------------------------------------------------------
  // Program counter
  // ---------------------------------------------------------------------------
  instruction_fetch_pc_register #(
    .RESET_PC (RESET_PC)
  ) u_pc_register (
    .clk            (clk),
    .rst_n          (rst_n),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .advance        (capture),
    .pc             (pc)
  );

  // Straight wire from the pc register: no logic between pc and memory.
  assign imem_addr = pc;

  // ---------------------------------------------------------------------------
  // FSM next state and capture decision
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    capture = 1'b0;

    if (redirect_valid) begin
      // Redirect outranks everything, including halt in the same cycle.
      state_d = S_RUN;
    end else begin
      unique case (state_q)
        S_IDLE: state_d = halt ? S_HALT : S_RUN;
        S_RUN: begin
          if (halt) begin
            state_d = S_HALT;
          end else begin
            capture = slot_free;
          end
        end
        S_HALT: state_d = S_HALT;
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Output valid: flush on redirect, set on capture, clear once drained.
  // A capture with a simultaneous accept keeps valid high (no bubble).
  always_comb begin
    out_valid_d = out_valid_q;
    if (redirect_valid) begin
      out_valid_d = 1'b0;
    end else if (capture) begin
      out_valid_d = 1'b1;
    end else if (accept) begin
      out_valid_d = 1'b0;
    end
  end

  // ---------------------------------------------------------------------------
  // State, IF/ID output register and handshake counter
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      out_valid_q   <= 1'b0;
      fetch_count_q <= '0;
    end else begin
      state_q     <= state_d;
      out_valid_q <= out_valid_d;
      // Counts even when a redirect flushes this edge: decode already took it.
      if (accept) begin
        fetch_count_q <= fetch_count_q + COUNT_WIDTH'(1);
      end
    end
  end

  // NOTE: the payload registers are reset too, so out_instr/out_pc read as a
  // defined NOP/0 after reset rather than X, even though out_valid gates them.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_instr_q <= NOP;
      out_pc_q    <= '0;
    end else if (capture) begin
      out_instr_q <= imem_instr;
      out_pc_q    <= pc;
    end
  end

  assign out_valid   = out_valid_q;
  assign out_instr   = out_instr_q;
  assign out_pc      = out_pc_q;
  assign halted      = (state_q == S_HALT);
  assign fetch_count = fetch_count_q;

endmodule : instruction_fetch

// File: tb/tb_instruction_fetch.sv
// -----------------------------------------------------------------------------
// tb_instruction_fetch
// Directed bench for instruction_fetch. The memory holds word index i at
// byte address 4*i. The stimulus pushes the (pc, instr) pairs decode is
// expected to accept into a queue; a monitor on the falling edge pops and
// compares on every handshake. Stimulus also checks control outputs directly.
// -----------------------------------------------------------------------------
module tb_instruction_fetch;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic [31:0] imem_addr;
  logic [31:0] imem_instr;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        halt;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
  logic        halted;
  logic [31:0] fetch_count;

  int   checks = 0;
  int   errors = 0;
  exp_t sb_q[$];

  instruction_fetch dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem_addr      (imem_addr),
    .imem_instr     (imem_instr),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .halt           (halt),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_instr      (out_instr),
    .out_pc         (out_pc),
    .halted         (halted),
    .fetch_count    (fetch_count)
  );

  // Combinational memory: word i holds the value i.
  assign imem_instr = imem_addr >> 2;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic expect_item(input logic [31:0] pc, input logic [31:0] instr);
    exp_t e;
    e.pc    = pc;
    e.instr = instr;
    sb_q.push_back(e);
  endtask

  // Advance to 1 time unit after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard monitor: every handshake must match the next expected item.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (sb_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_accept: out_pc 0x%08h with empty scoreboard", out_pc);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        check("sb_out_pc", out_pc, e.pc);
        check("sb_out_instr", out_instr, e.instr);
      end
    end
  end

  // Watchdog: the directed sequence is short; anything longer is a hang.
  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n          = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    halt           = 1'b0;
    out_ready      = 1'b1;

    // ---- Reset state --------------------------------------------------------
    #2;
    check("rst_out_valid", {31'b0, out_valid}, 32'd0);
    check("rst_fetch_count", fetch_count, 32'd0);
    check("rst_imem_addr", imem_addr, 32'h0);
    check("rst_out_pc", out_pc, 32'h0);
    check("rst_out_instr", out_instr, 32'h0);
    check("rst_halted", {31'b0, halted}, 32'd0);
    tick();
    tick();
    rst_n = 1'b1;

    // ---- 1. Reset then run --------------------------------------------------
    expect_item(32'h0, 32'd0);
    expect_item(32'h4, 32'd1);
    expect_item(32'h8, 32'd2);
    tick();  // S_IDLE -> S_RUN, no capture
    check("idle_out_valid", {31'b0, out_valid}, 32'd0);
    check("idle_imem_addr", imem_addr, 32'h0);
    tick();  // first capture
    check("run_imem_addr", imem_addr, 32'h4);
    tick();
    tick();
    tick();  // third accept
    out_ready = 1'b0;
    check("run_fetch_count", fetch_count, 32'd3);
    check("run_imem_addr2", imem_addr, 32'h10);

    // ---- 2. Backpressure ----------------------------------------------------
    for (int i = 0; i < 3; i++) begin
      tick();
      check("bp_out_pc", out_pc, 32'hC);
      check("bp_out_instr", out_instr, 32'd3);
      check("bp_imem_addr", imem_addr, 32'h10);
      check("bp_fetch_count", fetch_count, 32'd3);
    end
    expect_item(32'hC, 32'd3);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("bp_release_out_pc", out_pc, 32'h10);
    check("bp_release_out_instr", out_instr, 32'd4);
    check("bp_release_count", fetch_count, 32'd4);

    // ---- 3. Redirect while stalled -----------------------------------------
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0022;
    tick();
    redirect_valid = 1'b0;
    out_ready      = 1'b1;
    check("redir_out_valid", {31'b0, out_valid}, 32'd0);
    check("redir_imem_addr", imem_addr, 32'h20);
    check("redir_fetch_count", fetch_count, 32'd4);
    expect_item(32'h20, 32'd8);
    expect_item(32'h24, 32'd9);
    tick();
    check("redir_imem_addr2", imem_addr, 32'h24);
    tick();

    // ---- 4. Halt ------------------------------------------------------------
    halt = 1'b1;
    tick();
    check("halt_halted", {31'b0, halted}, 32'd1);
    check("halt_out_valid", {31'b0, out_valid}, 32'd0);
    check("halt_imem_addr", imem_addr, 32'h28);
    check("halt_fetch_count", fetch_count, 32'd6);
    tick();
    tick();
    halt = 1'b0;
    tick();
    tick();
    check("halt_hold_halted", {31'b0, halted}, 32'd1);
    check("halt_hold_out_valid", {31'b0, out_valid}, 32'd0);
    check("halt_hold_imem_addr", imem_addr, 32'h28);
    check("halt_hold_count", fetch_count, 32'd6);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0;
    expect_item(32'h0, 32'd0);
    tick();
    redirect_valid = 1'b0;
    check("resume_halted", {31'b0, halted}, 32'd0);
    check("resume_imem_addr", imem_addr, 32'h0);
    check("resume_out_valid", {31'b0, out_valid}, 32'd0);
    tick();  // captures pc 0

    // ---- 5. Wrap, with a redirect that coincides with an accept -------------
    redirect_valid = 1'b1;
    redirect_pc    = 32'hFFFF_FFFC;
    expect_item(32'hFFFF_FFFC, 32'h3FFF_FFFF);
    tick();
    redirect_valid = 1'b0;
    check("wrap_flush_out_valid", {31'b0, out_valid}, 32'd0);
    check("wrap_accept_on_redirect", fetch_count, 32'd7);
    check("wrap_imem_addr", imem_addr, 32'hFFFF_FFFC);
    tick();
    check("wrap_pc_zero", imem_addr, 32'h0);
    tick();
    out_ready = 1'b0;
    check("wrap_out_pc", out_pc, 32'h0);
    check("wrap_out_instr", out_instr, 32'h0);
    check("wrap_out_valid", {31'b0, out_valid}, 32'd1);
    check("wrap_fetch_count", fetch_count, 32'd8);

    // ---- 6. Asynchronous reset mid-stream -----------------------------------
    #1;
    rst_n = 1'b0;
    #1;
    check("arst_out_valid", {31'b0, out_valid}, 32'd0);
    check("arst_fetch_count", fetch_count, 32'd0);
    check("arst_imem_addr", imem_addr, 32'h0);
    check("arst_halted", {31'b0, halted}, 32'd0);
    #1;
    rst_n     = 1'b1;
    out_ready = 1'b1;
    expect_item(32'h0, 32'd0);
    tick();  // S_IDLE
    check("arst_idle_out_valid", {31'b0, out_valid}, 32'd0);
    check("arst_idle_imem_addr", imem_addr, 32'h0);
    tick();  // capture pc 0
    tick();  // accept pc 0, capture pc 4
    out_ready = 1'b0;
    check("arst_restart_count", fetch_count, 32'd1);
    check("arst_restart_out_pc", out_pc, 32'h4);
    check("arst_restart_out_instr", out_instr, 32'd1);

    tick();
    check("scoreboard_drained", sb_q.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_instruction_fetch

// File: doc/instruction_fetch.md
Name: instruction_fetch

Overview:
Fetch stage that owns the program counter and drives the combinational instruction_memory. It presents pc as the memory byte address, with word index = address >> 2. Each returned instruction is captured with its pc into a registered IF/ID output governed by a valid/ready handshake toward decode. Branch/jump redirects from execute flush the output and restart fetch; a halt request freezes fetch.

Parameters:
RESET_PC, 32'h0000_0000, pc value loaded on reset; low 2 bits must be 0.
COUNT_WIDTH, 32, width of fetch_count.

Ports:
clk  input  1  clock; all state updates on rising edge.
rst_n  input  1  asynchronous, active-low reset.
imem_addr  output  32  byte address to instruction_memory; always equals pc.
imem_instr  input  32  instruction returned combinationally by instruction_memory for imem_addr.
redirect_valid  input  1  one-cycle request to redirect pc (taken branch/jump).
redirect_pc  input  32  redirect target; bits [1:0] are ignored (forced to 0).
halt  input  1  level request to stop fetching.
out_valid  output  1  out_instr/out_pc hold a valid fetched instruction.
out_ready  input  1  decode accepts the output this cycle.
out_instr  output  32  fetched instruction.
out_pc  output  32  address the instruction was fetched from.
halted  output  1  high while FSM is in S_HALT.
fetch_count  output  COUNT_WIDTH  number of accepted handshakes (out_valid && out_ready); wraps modulo 2^COUNT_WIDTH.

Behaviour:
- Reset (asynchronous on rst_n low, released synchronously by design):
  - pc = RESET_PC; out_valid = 0; out_instr = 0; out_pc = 0; fetch_count = 0; state = S_IDLE; halted = 0.
- imem_addr is combinational from the pc register, with no extra logic in the path. Fetch latency is 1 cycle: the instruction at pc appears on out_instr on the edge after pc is presented.
- Definitions:
  - accept = out_valid && out_ready.
  - slot_free = !out_valid || out_ready.
- FSM states:
  - S_IDLE: first cycle after reset release. No capture; the next state is S_RUN unconditionally, or S_HALT if halt is high. This cycle lets the memory settle.
  - S_RUN: if slot_free, then out_instr <= imem_instr, out_pc <= pc, out_valid <= 1, pc <= pc + 4. Otherwise everything holds (stall) and imem_addr stays stable.
  - S_HALT: no new captures and pc holds. The existing output drains on accept, then out_valid <= 0.
- Per-edge priority, highest first:
  1. redirect_valid: pc <= {redirect_pc[31:2], 2'b00}; out_valid <= 0 (flush, regardless of out_ready); state <= S_RUN, even from S_HALT; halt that same cycle is ignored.
  2. halt in S_RUN: state <= S_HALT and no capture this cycle. A pending output remains valid until accepted.
  3. Normal S_RUN or S_HALT behaviour as above.
- Leaving S_HALT requires redirect_valid or reset. halt deasserting alone does not resume fetch.
- fetch_count increments on every accept, including an accept in the same cycle as a redirect flush, because the consumer already took the output.
- pc arithmetic is 32-bit unsigned and wraps: pc 32'hFFFF_FFFC + 4 gives 32'h0000_0000.
- Simultaneous accept and capture in S_RUN: the output is replaced the same edge with no bubble, so throughput is one instruction per cycle.
- rst_n asserted mid-operation: all state returns immediately to reset values, and out_valid drops asynchronously.

Decomposition:
- Shared package: XLEN = 32, PC_STEP = 4, the fetch state enum (S_IDLE, S_RUN, S_HALT), and NOP encoding 32'h0.
- Natural sub-module: pc_register, holding pc with next-pc mux (redirect / increment / hold), RESET_PC parameter, and asynchronous active-low reset.
- The FSM and IF/ID output register stay in instruction_fetch.

Test Plan:
1. Reset then run: with out_ready = 1 and memory words {0, 1, 2, …}, after reset release imem_addr runs 0, 4, 8, …. out_instr shows 0, 1, 2 with out_pc 0, 4, 8 on consecutive cycles; fetch_count = 3 after three accepts.
2. Backpressure: hold out_ready = 0 for 3 cycles while out_pc = 4. out_instr = 1, out_pc = 4 and imem_addr = 8 stay stable. On out_ready = 1, the next cycle shows out_pc = 8 with no duplicate and no skip.
3. Redirect: assert redirect_valid with redirect_pc = 32'h0000_0022 while out_valid = 1 and out_ready = 0. The next cycle has out_valid = 0 and imem_addr = 32'h20. The following cycle has out_pc = 32'h20, and fetch_count is unchanged.
4. Halt: assert halt at pc = 8 with out_ready = 1. halted = 1, pc stays 8, and the pending output (out_pc = 4) is accepted once, then out_valid = 0. Deasserting halt changes nothing. redirect_valid to 32'h0 resumes fetch with out_pc = 0.
5. Wrap: set pc to 32'hFFFF_FFFC via redirect. The next fetched out_pc = 32'hFFFF_FFFC, then out_pc = 32'h0.
6. Async reset mid-stream: pulse rst_n low between clock edges with out_valid = 1. out_valid, fetch_count and pc go to 0 immediately without a clock edge, and fetch restarts from RESET_PC after S_IDLE.
